// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: classifies decoder requests, formats bus byte lanes, runs the
// req/ready handshake with a timeout, and extends load data for the core.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic        mem_wr,
    input  logic [2:0]  dwidth,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic [1:0]  err,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      err_q, err_d;
    logic            bus_we_q, bus_we_d;
    logic [31:0]     bus_addr_q, bus_addr_d;
    logic [3:0]      bus_be_q, bus_be_d;
    logic [31:0]     bus_wdata_q, bus_wdata_d;
    logic [1:0]      lane_q, lane_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;

    logic            illegal, misaligned;
    logic [3:0]      be_fmt;
    logic [31:0]     wdata_fmt;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     ld_ext;

    // Request classification and store lane formatting from the live decoder inputs.
    always_comb begin
        illegal    = (dwidth[1:0] == 2'b11) || (dwidth == 3'b110) || (mem_wr && dwidth[2]);
        misaligned = ((dwidth[1:0] == 2'b01) && addr[0]) ||
                     ((dwidth[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        be_fmt     = 4'b1111;
        wdata_fmt  = wdata;
        unique case (dwidth[1:0])
            2'b00: begin
                be_fmt    = 4'b0001 << addr[1:0];
                wdata_fmt = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_fmt    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_fmt = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane selection and sign/zero extension using the registered access shape.
    always_comb begin
        unique case (lane_q)
            2'b00:   byte_sel = bus_rdata[7:0];
            2'b01:   byte_sel = bus_rdata[15:8];
            2'b10:   byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (size_q)
            2'b00:   ld_ext = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   ld_ext = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ld_ext = bus_rdata;
        endcase
    end

    // Next-state logic for the FSM, timeout counter and result/bus registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        lane_d      = lane_q;
        size_d      = size_q;
        uns_d       = uns_q;
        unique case (state_q)
            StIdle: begin
                if (lsu_valid) begin
                    if (illegal) begin
                        err_d   = 2'b10;
                        state_d = StResp;
                    end else if (misaligned) begin
                        err_d   = 2'b01;
                        state_d = StResp;
                    end else begin
                        bus_we_d    = mem_wr;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = be_fmt;
                        bus_wdata_d = mem_wr ? wdata_fmt : 32'd0;
                        lane_d      = addr[1:0];
                        size_d      = dwidth[1:0];
                        uns_d       = dwidth[2];
                        cnt_d       = '0;
                        state_d     = StBus;
                    end
                end
            end
            StBus: begin
                if (bus_ready) begin
                    if (!bus_we_q) begin
                        rdata_d = ld_ext;
                    end
                    err_d   = 2'b00;
                    state_d = StResp;
                end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 2'b11;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rdata_q     <= 32'd0;
            err_q       <= 2'b00;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            lane_q      <= 2'd0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
        end
    end

    // Outputs; stall covers the request cycle and the whole bus phase.
    always_comb begin
        done      = (state_q == StResp);
        bus_req   = (state_q == StBus);
        stall     = ((state_q == StIdle) && lsu_valid) || (state_q == StBus);
        rdata     = rdata_q;
        err       = err_q;
        bus_we    = bus_we_q;
        bus_addr  = bus_addr_q;
        bus_be    = bus_be_q;
        bus_wdata = bus_wdata_q;
    end

endmodule
